// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle: register indices and write/load/branch
// qualifiers from the pipeline, stall/flush/forward/mul-div controls back to it.
interface hazard_ctrl_if;
  logic [4:0] rs1_D;
  logic [4:0] rs2_D;
  logic [4:0] rs1_E;
  logic [4:0] rs2_E;
  logic [4:0] rd_E;
  logic [4:0] rd_M;
  logic [4:0] rd_W;
  logic       RegWrite_M;
  logic       RegWrite_W;
  logic       MemRead_E;
  logic       PCSrc_E;
  logic       MulDiv_E;
  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       StallE;
  logic       FlushE;
  logic       FlushM;
  logic [1:0] ForwardA_E;
  logic [1:0] ForwardB_E;
  logic       md_start;
  logic       md_done;

  // Pipeline side: supplies hazard sources, consumes controls.
  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           RegWrite_M, RegWrite_W, MemRead_E, PCSrc_E, MulDiv_E,
    input  StallF, StallD, FlushD, StallE, FlushE, FlushM,
           ForwardA_E, ForwardB_E, md_start, md_done
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           RegWrite_M, RegWrite_W, MemRead_E, PCSrc_E, MulDiv_E,
    output StallF, StallD, FlushD, StallE, FlushE, FlushM,
           ForwardA_E, ForwardB_E, md_start, md_done
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller and mul/div sequencer for the 5-stage pipeline.
// Optional saturating performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]  lw_stall_cnt,
  output logic [31:0]  md_stall_cnt,
  output logic [31:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             md_stall;
  logic             lw_stall;

  // x0 is never forwarded; MEM result is newer than WB so it wins.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wr_m, input logic [4:0] rd_m,
                                         input logic       wr_w, input logic [4:0] rd_w);
    if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (hz.MulDiv_E) begin
        state_nxt = BUSY;
        cnt_nxt   = CNT_W'(MD_LATENCY - 1);
      end
      BUSY: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      // The finished op is still in EX here, so MulDiv_E must not re-trigger.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hz.md_start = (state == IDLE) && hz.MulDiv_E;
    hz.md_done  = (state == DONE);
    md_stall    = hz.md_start || (state == BUSY);
  end

  always_comb begin
    lw_stall = hz.MemRead_E && (hz.rd_E != 5'd0) &&
               ((hz.rd_E == hz.rs1_D) || (hz.rd_E == hz.rs2_D));
    hz.StallF     = lw_stall | md_stall;
    hz.StallD     = lw_stall | md_stall;
    hz.StallE     = md_stall;
    hz.FlushM     = md_stall;
    // The held mul/div instruction in EX must never be flushed.
    hz.FlushE     = (lw_stall | hz.PCSrc_E) & ~md_stall;
    hz.FlushD     = hz.PCSrc_E & ~md_stall;
    hz.ForwardA_E = fwd_sel(hz.rs1_E, hz.RegWrite_M, hz.rd_M, hz.RegWrite_W, hz.rd_W);
    hz.ForwardB_E = fwd_sel(hz.rs2_E, hz.RegWrite_M, hz.rd_M, hz.RegWrite_W, hz.rd_W);
  end

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && v != 32'hFFFF_FFFF) return v + 32'd1;
    else                          return v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lw_stall_cnt <= '0;
      md_stall_cnt <= '0;
      flush_cnt    <= '0;
    end else begin
      lw_stall_cnt <= sat_inc(lw_stall_cnt, lw_stall & ~md_stall);
      md_stall_cnt <= sat_inc(md_stall_cnt, md_stall);
      flush_cnt    <= sat_inc(flush_cnt, hz.FlushD);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MD_LATENCY=4: forwarding, load-use, branch,
// mul/div sequencing, async reset abort and (when enabled) the performance counters.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lw_stall_cnt, md_stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .lw_stall_cnt (lw_stall_cnt),
    .md_stall_cnt (md_stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {StallF, StallD, FlushD, StallE, FlushE, FlushM, md_start, md_done}
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_LW   = 8'b1100_1000;
  localparam logic [7:0] C_BR   = 8'b0010_1000;
  localparam logic [7:0] C_LWBR = 8'b1110_1000;
  localparam logic [7:0] C_MD0  = 8'b1101_0110;
  localparam logic [7:0] C_MDB  = 8'b1101_0100;
  localparam logic [7:0] C_DONE = 8'b0000_0001;

  function automatic logic [7:0] ctl();
    return {hz.StallF, hz.StallD, hz.FlushD, hz.StallE,
            hz.FlushE, hz.FlushM, hz.md_start, hz.md_done};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    hz.rs1_D = 0; hz.rs2_D = 0; hz.rs1_E = 0; hz.rs2_E = 0;
    hz.rd_E = 0; hz.rd_M = 0; hz.rd_W = 0;
    hz.RegWrite_M = 0; hz.RegWrite_W = 0; hz.MemRead_E = 0;
    hz.PCSrc_E = 0; hz.MulDiv_E = 0;
  endtask

  // Move to 2 time units after the next rising edge; inputs change and
  // outputs are checked here, well clear of the active edge.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    #12;
    check("reset_ctl", 32'(ctl()), 32'(C_NONE));
    check("reset_fwdA", 32'(hz.ForwardA_E), 32'd0);
    check("reset_fwdB", 32'(hz.ForwardB_E), 32'd0);
    next_cycle();
    reset = 1'b0;

    // Forwarding
    hz.rd_M = 5; hz.RegWrite_M = 1; hz.rd_W = 5; hz.RegWrite_W = 1; hz.rs1_E = 5; #1;
    check("fwdA_mem", 32'(hz.ForwardA_E), 32'd2);
    hz.RegWrite_M = 0; #1;
    check("fwdA_wb", 32'(hz.ForwardA_E), 32'd1);
    hz.rd_W = 0; hz.rs1_E = 0; #1;
    check("fwdA_x0", 32'(hz.ForwardA_E), 32'd0);
    hz.rs2_E = 9; hz.rd_W = 9; hz.RegWrite_W = 1; #1;
    check("fwdB_wb", 32'(hz.ForwardB_E), 32'd1);
    hz.rd_M = 9; hz.RegWrite_M = 1; #1;
    check("fwdB_mem", 32'(hz.ForwardB_E), 32'd2);
    check("fwdA_nomatch", 32'(hz.ForwardA_E), 32'd0);
    hz.rs2_E = 0; hz.rd_M = 0; hz.rd_W = 0; #1;
    check("fwdB_x0", 32'(hz.ForwardB_E), 32'd0);
    clear_inputs(); #1;

    // Load-use and branch
    hz.MemRead_E = 1; hz.rd_E = 7; hz.rs2_D = 7; #1;
    check("lw_rs2", 32'(ctl()), 32'(C_LW));
    hz.rd_E = 0; hz.rs2_D = 0; #1;
    check("lw_x0", 32'(ctl()), 32'(C_NONE));
    hz.rd_E = 3; hz.rs1_D = 3; #1;
    check("lw_rs1", 32'(ctl()), 32'(C_LW));
    hz.MemRead_E = 0; #1;
    check("lw_noload", 32'(ctl()), 32'(C_NONE));
    hz.PCSrc_E = 1; #1;
    check("branch", 32'(ctl()), 32'(C_BR));
    hz.MemRead_E = 1; #1;
    check("branch_lw", 32'(ctl()), 32'(C_LWBR));
    clear_inputs();

    // Mul/div held in EX for 4 cycles, done on cycle 4
    next_cycle();
    hz.MulDiv_E = 1; #1;
    check("md_c0", 32'(ctl()), 32'(C_MD0));
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      hz.PCSrc_E = (c == 2);
      hz.MemRead_E = (c == 1); hz.rd_E = 7; hz.rs2_D = 7;
      #1;
      check($sformatf("md_c%0d", c), 32'(ctl()), 32'(C_MDB));
    end
    next_cycle();
    hz.PCSrc_E = 0; hz.MemRead_E = 0; hz.rd_E = 0; hz.rs2_D = 0; #1;
    check("md_c4_done", 32'(ctl()), 32'(C_DONE));

    // Back-to-back op starts fresh from IDLE
    next_cycle(); #1;
    check("md_b2b_start", 32'(ctl()), 32'(C_MD0));
    next_cycle(); #1;
    check("md_b2b_c1", 32'(ctl()), 32'(C_MDB));
    next_cycle();
    reset = 1'b1; hz.MulDiv_E = 0; #1;
    check("rst_abort", 32'(ctl()), 32'(C_NONE));
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      next_cycle(); #1;
      check($sformatf("post_rst_c%0d", c), 32'(ctl()), 32'(C_NONE));
    end
    hz.MulDiv_E = 1; #1;
    check("md_restart", 32'(ctl()), 32'(C_MD0));
    for (int c = 1; c <= 4; c++) next_cycle();
    #1;
    check("md_restart_done", 32'(ctl()), 32'(C_DONE));
    next_cycle();
    hz.MulDiv_E = 0; #1;
    check("md_idle", 32'(ctl()), 32'(C_NONE));

`ifdef HAZARD_PERF_CNT_EN
    reset = 1'b1; #1;
    check("perf_rst_lw", lw_stall_cnt, 32'd0);
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hz.MemRead_E = 1; hz.rd_E = 4; hz.rs1_D = 4;
      next_cycle();
      clear_inputs();
      next_cycle();
    end
    hz.MulDiv_E = 1;
    for (int c = 0; c < 5; c++) next_cycle();
    hz.MulDiv_E = 0;
    for (int i = 0; i < 2; i++) begin
      hz.PCSrc_E = 1;
      next_cycle();
      hz.PCSrc_E = 0;
      next_cycle();
    end
    check("perf_lw", lw_stall_cnt, 32'd3);
    check("perf_md", md_stall_cnt, 32'd4);
    check("perf_flush", flush_cnt, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
